// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory port of the
// unified-memory arbiter.
//   slave  : the arbiter side (takes requests, drives acks and the memory bus)
//   master : the environment side (pipeline ports plus backing memory)
// Fetch port : i_req/i_addr in, i_ack/i_rdata/i_stall out
// Data port  : d_req/d_we/d_addr/d_wdata in, d_ack/d_rdata/d_stall out
// Memory port: mem_req/mem_we/mem_addr/mem_wdata/mem_owner out,
//              mem_rdata/mem_ready in
// err        : pulses together with the ack of a timed-out transaction
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port backing memory between the instruction-fetch port
// and the data (MEM-stage) port. Data has priority, but fetch is granted once
// STARVE_LIMIT consecutive data grants have gone by while it was waiting.
// Each transaction runs IDLE -> BUSY -> DONE; a BUSY phase with no memory
// response for TIMEOUT cycles is aborted with err (TIMEOUT = 0 disables it).
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory handshakes)
// All bus outputs are registered except i_stall and d_stall.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [SC_W-1:0] starve_cnt;
  logic [TC_W-1:0] tmo_cnt;
  logic            grant_data;
  logic            grant_fetch;
  logic            timeout_hit;

  // Data wins unless fetch is waiting and has already watched STARVE_LIMIT
  // data grants go by in a row.
  assign grant_data  = bus.d_req && !(bus.i_req && (starve_cnt == SC_MAX));
  assign grant_fetch = bus.i_req && !grant_data;
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == TC_LAST);

  assign bus.i_stall = bus.i_req & ~bus.i_ack;
  assign bus.d_stall = bus.d_req & ~bus.d_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_owner <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.err       <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data || grant_fetch) begin
            state         <= BUSY;
            bus.mem_req   <= 1'b1;
            bus.mem_owner <= grant_data;
            tmo_cnt       <= '0;
            if (grant_data) begin
              bus.mem_addr  <= bus.d_addr;
              bus.mem_we    <= bus.d_we;
              bus.mem_wdata <= bus.d_wdata;
              // Only data grants that overtake a waiting fetch count.
              starve_cnt    <= bus.i_req ? starve_cnt + SC_W'(1) : '0;
            end else begin
              bus.mem_addr  <= bus.i_addr;
              bus.mem_we    <= 1'b0;
              starve_cnt    <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            state       <= DONE;
            if (bus.mem_owner) begin
              bus.d_ack <= 1'b1;
              // A write returns nothing; the last read value stays visible.
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= bus.mem_rdata;
            end
          end else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b1;
            state       <= DONE;
            if (bus.mem_owner) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= '0;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TC_W'(1);
          end
        end
        DONE: begin
          // Requesters see the ack at this closing edge, so IDLE never
          // observes the request that was just served.
          state     <= IDLE;
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 2;
  localparam int TIMEOUT      = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} phase_t;

  // Reference-model state for the randomized phase
  phase_t      m_state;
  int          starve;
  logic        m_owner, m_we, m_err, m_hang, m_resp_got;
  logic [31:0] m_addr, m_wdata, m_resp;
  int          m_wait, m_busy_cycles;
  logic        i_pend, d_pend, rel_i, rel_d, issue_en;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  logic [31:0] mem_model [logic [31:0]];

  logic        own;
  logic [5:0]  exp_order;
  logic [31:0] prev_d;
  int          cnt;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a memory request, then answers it in that cycle.
  // Returns in the DONE cycle with the granted owner.
  task automatic serve(input logic [31:0] rd, output logic owner);
    int k;
    k = 0;
    while (!bus.mem_req && k < 10) begin
      step();
      k++;
    end
    chk("serve_wait", 32'(bus.mem_req), 32'(1));
    owner         = bus.mem_owner;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    reset = 1'b1;

    // ---- reset state
    step();
    chk("rst_mem_req",   32'(bus.mem_req), 0);
    chk("rst_mem_we",    32'(bus.mem_we), 0);
    chk("rst_owner",     32'(bus.mem_owner), 0);
    chk("rst_i_ack",     32'(bus.i_ack), 0);
    chk("rst_d_ack",     32'(bus.d_ack), 0);
    chk("rst_err",       32'(bus.err), 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_rdata",   bus.i_rdata, 0);
    chk("rst_d_rdata",   bus.d_rdata, 0);
    reset = 1'b0;
    step();

    // ---- fetch read
    bus.i_req = 1; bus.i_addr = 32'h10;
    #1 chk("t1_i_stall_c0", 32'(bus.i_stall), 1);
    step();
    chk("t1_mem_req_c1", 32'(bus.mem_req), 1);
    chk("t1_owner_c1",   32'(bus.mem_owner), 0);
    chk("t1_addr_c1",    bus.mem_addr, 32'h10);
    chk("t1_we_c1",      32'(bus.mem_we), 0);
    chk("t1_i_stall_c1", 32'(bus.i_stall), 1);
    step();
    chk("t1_mem_req_c2", 32'(bus.mem_req), 1);
    chk("t1_i_stall_c2", 32'(bus.i_stall), 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    bus.mem_ready = 0;
    chk("t1_i_ack_c3",   32'(bus.i_ack), 1);
    chk("t1_i_rdata_c3", bus.i_rdata, 32'hDEADBEEF);
    chk("t1_i_stall_c3", 32'(bus.i_stall), 0);
    chk("t1_mem_req_c3", 32'(bus.mem_req), 0);
    chk("t1_err_c3",     32'(bus.err), 0);
    step();
    bus.i_req = 0;
    chk("t1_i_ack_c4",   32'(bus.i_ack), 0);
    chk("t1_i_rdata_c4", bus.i_rdata, 32'hDEADBEEF);
    step();

    // ---- simultaneous requests: data first, then fetch
    bus.i_req = 1; bus.i_addr = 32'h30;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20;
    #1 chk("t2_d_stall_c0", 32'(bus.d_stall), 1);
    step();
    chk("t2_mem_req_c1", 32'(bus.mem_req), 1);
    chk("t2_owner_c1",   32'(bus.mem_owner), 1);
    chk("t2_addr_c1",    bus.mem_addr, 32'h20);
    chk("t2_i_stall_c1", 32'(bus.i_stall), 1);
    chk("t2_d_stall_c1", 32'(bus.d_stall), 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hA5A50001;
    step();
    bus.mem_ready = 0;
    chk("t2_d_ack_c2",   32'(bus.d_ack), 1);
    chk("t2_i_ack_c2",   32'(bus.i_ack), 0);
    chk("t2_d_rdata_c2", bus.d_rdata, 32'hA5A50001);
    chk("t2_d_stall_c2", 32'(bus.d_stall), 0);
    chk("t2_i_stall_c2", 32'(bus.i_stall), 1);
    step();
    bus.d_req = 0;
    #1 chk("t2_d_stall_c3", 32'(bus.d_stall), 0);
    chk("t2_i_stall_c3", 32'(bus.i_stall), 1);
    step();
    chk("t2_mem_req_c4", 32'(bus.mem_req), 1);
    chk("t2_owner_c4",   32'(bus.mem_owner), 0);
    chk("t2_addr_c4",    bus.mem_addr, 32'h30);
    bus.mem_ready = 1; bus.mem_rdata = 32'hC0DE0002;
    step();
    bus.mem_ready = 0;
    chk("t2_i_ack_c5",   32'(bus.i_ack), 1);
    chk("t2_i_rdata_c5", bus.i_rdata, 32'hC0DE0002);
    step();
    bus.i_req = 0;
    step();

    // ---- starvation limit 2: order D D I D D I (bit g = 1 means data)
    exp_order = 6'b011011;
    bus.i_req = 1; bus.i_addr = 32'h50;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60;
    for (int g = 0; g < 6; g++) begin
      serve(32'h50000000 + 32'(g), own);
      chk($sformatf("t3_order_g%0d", g), 32'(own), 32'(exp_order[g]));
      chk($sformatf("t3_ack_g%0d", g), 32'(own ? bus.d_ack : bus.i_ack), 1);
      step();
    end
    bus.i_req = 0; bus.d_req = 0;
    step();

    // ---- data write leaves d_rdata untouched
    prev_d = 32'h50000004;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
    step();
    chk("t4_mem_req", 32'(bus.mem_req), 1);
    chk("t4_mem_we",  32'(bus.mem_we), 1);
    chk("t4_wdata",   bus.mem_wdata, 32'h12345678);
    chk("t4_addr",    bus.mem_addr, 32'h40);
    chk("t4_owner",   32'(bus.mem_owner), 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0BAD0;
    step();
    bus.mem_ready = 0;
    chk("t4_d_ack",   32'(bus.d_ack), 1);
    chk("t4_d_rdata", bus.d_rdata, prev_d);
    chk("t4_err",     32'(bus.err), 0);
    step();
    bus.d_req = 0; bus.d_we = 0;
    step();

    // ---- timeout: mem_req high for exactly TIMEOUT cycles
    bus.i_req = 1; bus.i_addr = 32'h70;
    step();
    cnt = 0;
    while (bus.mem_req && cnt < 20) begin
      cnt++;
      step();
    end
    chk("t5_busy_cycles", 32'(cnt), 32'(TIMEOUT));
    chk("t5_i_ack",   32'(bus.i_ack), 1);
    chk("t5_err",     32'(bus.err), 1);
    chk("t5_i_rdata", bus.i_rdata, 0);
    step();
    bus.i_req = 0;
    chk("t5_err_after",  32'(bus.err), 0);
    chk("t5_ack_after",  32'(bus.i_ack), 0);
    chk("t5_req_after",  32'(bus.mem_req), 0);
    step();

    // ---- reset in the middle of BUSY
    bus.i_req = 1; bus.i_addr = 32'h80;
    step();
    chk("t6_mem_req_c1", 32'(bus.mem_req), 1);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("t6_mem_req", 32'(bus.mem_req), 0);
    chk("t6_i_ack",   32'(bus.i_ack), 0);
    chk("t6_err",     32'(bus.err), 0);
    chk("t6_i_rdata", bus.i_rdata, 0);
    chk("t6_addr",    bus.mem_addr, 0);
    chk("t6_owner",   32'(bus.mem_owner), 0);
    bus.i_req = 0;
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFFFFFF;
    step();
    bus.mem_ready = 0;
    chk("t6_late_ready_ack", 32'(bus.i_ack), 0);
    chk("t6_late_ready_req", 32'(bus.mem_req), 0);
    bus.i_req = 1; bus.i_addr = 32'h84;
    serve(32'h600D600D, own);
    chk("t6_new_owner",  32'(own), 0);
    chk("t6_new_ack",    32'(bus.i_ack), 1);
    chk("t6_new_rdata",  bus.i_rdata, 32'h600D600D);
    step();
    bus.i_req = 0;

    // ---- randomized traffic against the reference model
    m_state = M_IDLE; starve = 0;
    i_pend = 0; d_pend = 0; rel_i = 0; rel_d = 0; issue_en = 1;
    m_owner = 0; m_we = 0; m_err = 0; m_hang = 0; m_resp_got = 0;
    m_addr = 0; m_wdata = 0; m_resp = 0; m_wait = 0; m_busy_cycles = 0;
    exp_i_rdata = 32'h600D600D; exp_d_rdata = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (cyc >= 1500) issue_en = 0;
      if (!issue_en && !i_pend && !d_pend && m_state == M_IDLE) break;
      step();
      // phase of this cycle, from what was driven during the previous one
      case (m_state)
        M_IDLE: if (i_pend || d_pend) begin
          m_owner = d_pend && !(i_pend && starve == STARVE_LIMIT);
          starve  = (m_owner && i_pend) ? starve + 1 : 0;
          m_we    = m_owner ? bus.d_we : 1'b0;
          m_addr  = m_owner ? bus.d_addr : bus.i_addr;
          m_wdata = bus.d_wdata;
          m_hang  = ($urandom_range(0, 15) == 0);
          m_wait  = $urandom_range(0, 3);
          m_resp_got = 0; m_busy_cycles = 0;
          m_state = M_BUSY;
          chk("r_grant_owner", 32'(bus.mem_owner), 32'(m_owner));
          chk("r_grant_addr",  bus.mem_addr, m_addr);
          chk("r_grant_we",    32'(bus.mem_we), 32'(m_we));
          if (m_owner) chk("r_grant_wdata", bus.mem_wdata, m_wdata);
        end
        M_BUSY: if (m_resp_got || m_busy_cycles == TIMEOUT) begin
          m_state = M_DONE;
          m_err   = !m_resp_got;
        end
        default: m_state = M_IDLE;
      endcase
      if (m_state == M_BUSY) m_busy_cycles++;
      if (m_state == M_DONE) begin
        if (m_err) begin
          if (m_owner) exp_d_rdata = 0; else exp_i_rdata = 0;
        end else if (!m_owner) exp_i_rdata = m_resp;
        else if (!m_we) exp_d_rdata = m_resp;
        else mem_model[m_addr] = m_wdata;
        if (m_owner) rel_d = 1; else rel_i = 1;
      end
      chk("r_mem_req", 32'(bus.mem_req), 32'(m_state == M_BUSY));
      chk("r_i_ack",   32'(bus.i_ack), 32'(m_state == M_DONE && !m_owner));
      chk("r_d_ack",   32'(bus.d_ack), 32'(m_state == M_DONE && m_owner));
      chk("r_err",     32'(bus.err),   32'(m_state == M_DONE && m_err));
      chk("r_i_rdata", bus.i_rdata, exp_i_rdata);
      chk("r_d_rdata", bus.d_rdata, exp_d_rdata);
      chk("r_i_stall", 32'(bus.i_stall), 32'(i_pend && !(m_state == M_DONE && !m_owner)));
      chk("r_d_stall", 32'(bus.d_stall), 32'(d_pend && !(m_state == M_DONE && m_owner)));

      // memory behaviour for this cycle
      bus.mem_ready = 0;
      if (m_state == M_BUSY) begin
        if (!m_hang) begin
          if (m_wait == 0) begin
            bus.mem_ready = 1;
            if (m_we) bus.mem_rdata = $urandom;
            else begin
              if (!mem_model.exists(m_addr)) mem_model[m_addr] = $urandom;
              bus.mem_rdata = mem_model[m_addr];
            end
            m_resp = bus.mem_rdata;
            m_resp_got = 1;
          end else m_wait--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_ready = 1;
        bus.mem_rdata = $urandom;
      end

      // requesters: drop a served request from the cycle after the ack
      if (rel_i && m_state != M_DONE) begin
        rel_i = 0; i_pend = 0; bus.i_req = 0;
      end
      if (rel_d && m_state != M_DONE) begin
        rel_d = 0; d_pend = 0; bus.d_req = 0;
      end
      if (!i_pend && issue_en && $urandom_range(0, 2) == 0) begin
        i_pend = 1; bus.i_req = 1;
        bus.i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_pend && issue_en && $urandom_range(0, 2) == 0) begin
        d_pend = 1; bus.d_req = 1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 32'($urandom_range(0, 15)) << 2;
        bus.d_wdata = $urandom;
      end
    end
    chk("r_drained", 32'(i_pend || d_pend), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port backing memory between the instruction-fetch port and the data (MEM-stage) port of the 5-stage pipeline, which then runs from a unified memory.
- Arbitrates with data priority plus an anti-starvation limit for fetch.
- Drives a req/ready handshake to the memory and returns registered read data and ack pulses.
- Produces per-port stall signals for the pipeline hazard logic.
- Aborts a transaction that receives no memory response within a timeout.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, max consecutive data grants while fetch waits (>=1)
TIMEOUT, 64, max BUSY cycles before abort; 0 disables timeout

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch address; stable while i_req
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DATA_W  fetch data, valid with i_ack, held after
i_stall  out  1  i_req & ~i_ack (combinational)
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = write, 0 = read; stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  read data, valid with d_ack on reads
d_stall  out  1  d_req & ~d_ack (combinational)
err  out  1  pulses with i_ack/d_ack when the transaction timed out
mem_req  out  1  request to backing memory, held until mem_ready
mem_we  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  one-cycle memory completion
mem_owner  out  1  0 = fetch, 1 = data; valid while mem_req

Behaviour:
All outputs are registered except i_stall and d_stall.

Reset (synchronous, on the edge where reset=1):
- state=IDLE; mem_req, mem_we, i_ack, d_ack, err, mem_owner = 0.
- mem_addr, mem_wdata, i_rdata, d_rdata = 0; starve_cnt and tmo_cnt = 0.
- Reset mid-BUSY abandons the transaction silently: no ack, no err.
- A mem_ready arriving in IDLE or DONE is ignored.

FSM states: IDLE, BUSY, DONE.

IDLE:
- No request: stay in IDLE.
- Only d_req: grant data.
- Only i_req: grant fetch.
- Both requests: grant fetch if starve_cnt==STARVE_LIMIT, else grant data.
- On a grant:
  - Next state is BUSY; mem_req<=1.
  - mem_addr, mem_we and mem_wdata are loaded from the granted port. mem_we=0 and mem_wdata is unchanged for fetch.
  - mem_owner is set to the granted port; tmo_cnt<=0.
- starve_cnt update on a grant:
  - Data grant with i_req=1: increment.
  - Data grant with i_req=0: clear.
  - Fetch grant: clear.

BUSY (mem_req held, mem_* stable):
- mem_ready=1:
  - mem_req<=0; next state DONE.
  - The owner's ack<=1.
  - Owner's rdata<=mem_rdata, except on a data write, where d_rdata keeps its value.
- mem_ready=0 with TIMEOUT!=0 and tmo_cnt==TIMEOUT-1:
  - mem_req<=0; next state DONE.
  - Owner's ack<=1 and err<=1; owner's rdata<=0.
- Otherwise tmo_cnt increments.

DONE (exactly one cycle):
- The ack (and err, if set) is high during this cycle; all are cleared on exit; next state is IDLE.
- The requester samples ack at the closing edge and drops or replaces its request from the following cycle. IDLE therefore never sees a stale request.

Timing and ordering:
- Latency: request seen at IDLE edge N -> mem_req high in cycle N+1. With mem_ready in cycle N+k (k>=1), ack is high in cycle N+k+1.
- Minimum per-transaction occupancy is 3 cycles (IDLE, BUSY, DONE).
- i_ack and d_ack are never high in the same cycle.
- A request that is dropped before being granted is legal and is simply not served.

Test Plan:
- Fetch read: i_req=1, i_addr=0x10 in cycle 0; mem_ready=1, mem_rdata=0xDEADBEEF in cycle 2 -> mem_req high in cycles 1-2 with mem_owner=0; i_ack=1 and i_rdata=0xDEADBEEF in cycle 3; i_stall=1 in cycles 0-2 and 0 in cycle 3.
- Simultaneous requests: i_req and d_req (read 0x20) rise together -> data is served first (mem_addr=0x20, mem_owner=1); after d_ack, fetch is granted; d_stall and i_stall track correctly throughout.
- Starvation with STARVE_LIMIT=2: i_req held high while d_req is re-asserted after every d_ack, memory responding in 1 cycle -> grant order D, D, I, D, D, I.
- Data write: d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1 and mem_wdata=0x12345678 while mem_req is high; d_ack pulses; d_rdata is unchanged from its prior value.
- Timeout with TIMEOUT=8: fetch granted and mem_ready never asserted -> mem_req high for exactly 8 cycles, then i_ack=1, err=1, i_rdata=0; next state IDLE.
- Reset mid-BUSY: reset=1 for one edge while mem_req=1 -> next cycle state=IDLE with all outputs 0; a late mem_ready is ignored (no ack); a new i_req is then served normally.
